// File: rtl/bpu_bimodal_predictor_if.sv
// Lookup, prediction, update and statistics signals exchanged between the
// fetch/resolve logic (master) and the bimodal branch predictor (slave).
interface bpu_bimodal_predictor_if #(
  parameter int IMM_W = 32,
  parameter int CNT_W = 16
);
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic [IMM_W-1:0] lookup_imm;
  logic             pred_valid;
  logic             pred_taken;
  logic [IMM_W-1:0] pred_imm;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             upd_pred;
  logic [CNT_W-1:0] mispred_count;

  modport master (
    output lookup_valid, lookup_pc, lookup_imm,
    output upd_valid, upd_pc, upd_taken, upd_pred,
    input  pred_valid, pred_taken, pred_imm, mispred_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_imm,
    input  upd_valid, upd_pc, upd_taken, upd_pred,
    output pred_valid, pred_taken, pred_imm, mispred_count
  );
endinterface

// File: rtl/bpu_bimodal_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// the low PC bits. A lookup registers taken/not-taken plus the branch offset
// one cycle later; the resolve stage trains the table and a saturating
// counter tracks mispredictions.
module bpu_bimodal_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int IMM_W      = 32,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  bpu_bimodal_predictor_if.slave   bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            table_r [DEPTH];
  logic [INDEX_BITS-1:0] lk_idx_s;
  logic [INDEX_BITS-1:0] up_idx_s;
  logic [1:0]            up_next_s;
  logic [1:0]            lk_ctr_s;
  logic                  mispred_s;
  logic                  pred_valid_r;
  logic                  pred_taken_r;
  logic [IMM_W-1:0]      pred_imm_r;
  logic [CNT_W-1:0]      mispred_count_r;
  logic                  unused_pc_bits_s;

  // Saturating step of a 2-bit counter toward taken (up) or not-taken (down).
  function automatic logic [1:0] ctr_step(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
    end else begin
      nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
    end
    return nxt;
  endfunction

  assign lk_idx_s  = bus.lookup_pc[INDEX_BITS-1:0];
  assign up_idx_s  = bus.upd_pc[INDEX_BITS-1:0];
  assign mispred_s = bus.upd_valid && (bus.upd_taken != bus.upd_pred);

  // Upper PC bits carry no meaning for a tagless table; folded here only so
  // they are visibly consumed and cannot influence any state.
  assign unused_pc_bits_s = ^{bus.lookup_pc[31:INDEX_BITS], bus.upd_pc[31:INDEX_BITS]};

  // Next counter value for the entry being trained, and the counter seen by a
  // lookup (forwarded when the same entry is trained at the same edge).
  always_comb begin
    up_next_s = ctr_step(table_r[up_idx_s], bus.upd_taken);
    lk_ctr_s  = table_r[lk_idx_s];
    if (bus.upd_valid && (up_idx_s == lk_idx_s)) begin
      lk_ctr_s = up_next_s;
    end else begin
      lk_ctr_s = table_r[lk_idx_s];
    end
  end

  // Counter table: weak-not-taken after reset, trained by resolved branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= 2'b01;
      end
    end else if (bus.upd_valid) begin
      table_r[up_idx_s] <= up_next_s;
    end
  end

  // Registered prediction; the offset holds its last value on idle cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
      pred_imm_r   <= {IMM_W{1'b0}};
    end else if (bus.lookup_valid) begin
      pred_valid_r <= 1'b1;
      pred_taken_r <= lk_ctr_s[1];
      pred_imm_r   <= bus.lookup_imm;
    end else begin
      pred_valid_r <= 1'b0;
      pred_taken_r <= 1'b0;
    end
  end

  // Misprediction statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      mispred_count_r <= {CNT_W{1'b0}};
    end else if (mispred_s && (mispred_count_r != CNT_MAX)) begin
      mispred_count_r <= mispred_count_r + CNT_ONE;
    end
  end

  assign bus.pred_valid    = pred_valid_r;
  assign bus.pred_taken    = pred_taken_r;
  assign bus.pred_imm      = pred_imm_r;
  assign bus.mispred_count = mispred_count_r;
endmodule

// File: tb/tb_bpu_bimodal_predictor.sv
// Testbench for bpu_bimodal_predictor: directed vector table, a CNT_W=4
// saturation sequence on a second instance, then randomized traffic
// compared against an array-based reference model.
module tb_bpu_bimodal_predictor;
  logic clk = 1'b0;
  logic reset;
  logic reset4;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bpu_bimodal_predictor_if #(.IMM_W(32), .CNT_W(16)) bus16 ();
  bpu_bimodal_predictor_if #(.IMM_W(32), .CNT_W(4))  bus4 ();

  bpu_bimodal_predictor #(.INDEX_BITS(6), .IMM_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus16.slave));
  bpu_bimodal_predictor #(.INDEX_BITS(6), .IMM_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset4), .bus(bus4.slave));

  typedef struct {
    bit          rst;
    bit          lv;
    logic [31:0] lpc;
    logic [31:0] limm;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    bit          up;
    bit          ev;
    bit          et;
    logic [31:0] eimm;
    int          ecnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model: counters as integers 0..3, counts as plain ints.
  int          m_ctr[64];
  int          m_cnt;
  bit          m_valid;
  bit          m_taken;
  logic [31:0] m_imm;

  function automatic vec_t mk(bit rst, bit lv, logic [31:0] lpc, logic [31:0] limm,
                              bit uv, logic [31:0] upc, bit ut, bit up,
                              bit ev, bit et, logic [31:0] eimm, int ecnt);
    vec_t v;
    v.rst = rst; v.lv = lv; v.lpc = lpc; v.limm = limm;
    v.uv = uv; v.upc = upc; v.ut = ut; v.up = up;
    v.ev = ev; v.et = et; v.eimm = eimm; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step(input vec_t v);
    int i;
    if (v.rst) begin
      for (int k = 0; k < 64; k++) m_ctr[k] = 1;
      m_cnt = 0; m_valid = 0; m_taken = 0; m_imm = 32'h0;
    end else begin
      if (v.uv) begin
        i = int'(v.upc % 32'd64);
        if (v.ut) m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        else      m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
        if (v.ut != v.up && m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if (v.lv) begin
        m_valid = 1;
        m_taken = (m_ctr[int'(v.lpc % 32'd64)] >= 2);
        m_imm   = v.limm;
      end else begin
        m_valid = 0;
        m_taken = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and sample after the edge.
  task automatic apply(input vec_t v);
    reset               = v.rst;
    bus16.lookup_valid  = v.lv;
    bus16.lookup_pc     = v.lpc;
    bus16.lookup_imm    = v.limm;
    bus16.upd_valid     = v.uv;
    bus16.upd_pc        = v.upc;
    bus16.upd_taken     = v.ut;
    bus16.upd_pred      = v.up;
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; reset4 = 1'b1;
    bus16.lookup_valid = 1'b0; bus16.lookup_pc = 32'h0; bus16.lookup_imm = 32'h0;
    bus16.upd_valid = 1'b0; bus16.upd_pc = 32'h0; bus16.upd_taken = 1'b0; bus16.upd_pred = 1'b0;
    bus4.lookup_valid = 1'b0; bus4.lookup_pc = 32'h0; bus4.lookup_imm = 32'h0;
    bus4.upd_valid = 1'b0; bus4.upd_pc = 32'h0; bus4.upd_taken = 1'b0; bus4.upd_pred = 1'b0;

    // Directed vectors: basic lookup, saturation, forwarding, aliasing, reset.
    vecs.push_back(mk(0,1,32'h5,32'h10, 0,32'h0,0,0, 1,0,32'h10,0));
    vecs.push_back(mk(0,0,32'h0,32'h0,  0,32'h0,0,0, 0,0,32'h10,0));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,1,0, 0,0,32'h10,1));
    vecs.push_back(mk(0,1,32'h5,32'h20, 0,32'h0,0,0, 1,1,32'h20,1));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,1,1, 0,0,32'h20,1));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,1,1, 0,0,32'h20,1));
    vecs.push_back(mk(0,1,32'h5,32'h30, 0,32'h0,0,0, 1,1,32'h30,1));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,0,1, 0,0,32'h30,2));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,0,1, 0,0,32'h30,3));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,0,0, 0,0,32'h30,3));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,0,0, 0,0,32'h30,3));
    vecs.push_back(mk(0,1,32'h5,32'h40, 0,32'h0,0,0, 1,0,32'h40,3));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h5,1,0, 0,0,32'h40,4));
    vecs.push_back(mk(0,1,32'h5,32'h50, 0,32'h0,0,0, 1,0,32'h50,4));
    vecs.push_back(mk(0,1,32'h7,32'h60, 1,32'h7,1,0, 1,1,32'h60,5));
    vecs.push_back(mk(0,1,32'hA,32'h70, 1,32'hB,1,1, 1,0,32'h70,5));
    vecs.push_back(mk(0,1,32'h7,32'h78, 1,32'h7,0,1, 1,0,32'h78,6));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h3,1,1, 0,0,32'h78,6));
    vecs.push_back(mk(0,0,32'h0,32'h0,  1,32'h3,1,1, 0,0,32'h78,6));
    vecs.push_back(mk(0,1,32'h43,32'h80, 0,32'h0,0,0, 1,1,32'h80,6));
    vecs.push_back(mk(0,1,32'hFFFFFFC3,32'h90, 0,32'h0,0,0, 1,1,32'h90,6));
    vecs.push_back(mk(1,1,32'h3,32'hA0, 1,32'h3,1,0, 0,0,32'h0,0));
    vecs.push_back(mk(0,1,32'h3,32'hB0, 0,32'h0,0,0, 1,0,32'hB0,0));
    vecs.push_back(mk(0,1,32'hB,32'hC0, 0,32'h0,0,0, 1,0,32'hC0,0));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk(0,0,32'h0,32'h0, 1,32'h20,1,0, 0,0,32'hC0,k));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0,0,32'h0,32'h0, 1,32'h20,1,1, 0,0,32'hC0,5));
    vecs.push_back(mk(0,1,32'h20,32'hD0, 0,32'h0,0,0, 1,1,32'hD0,5));

    // Reset state.
    v = mk(1,0,32'h0,32'h0, 0,32'h0,0,0, 0,0,32'h0,0);
    apply(v);
    apply(v);
    check("reset_valid", {31'b0, bus16.pred_valid}, 32'h0);
    check("reset_taken", {31'b0, bus16.pred_taken}, 32'h0);
    check("reset_imm",   bus16.pred_imm,            32'h0);
    check("reset_cnt",   {16'b0, bus16.mispred_count}, 32'h0);

    // Directed table.
    foreach (vecs[n]) begin
      apply(vecs[n]);
      check($sformatf("vec%0d_valid", n), {31'b0, bus16.pred_valid}, {31'b0, vecs[n].ev});
      check($sformatf("vec%0d_taken", n), {31'b0, bus16.pred_taken}, {31'b0, vecs[n].et});
      check($sformatf("vec%0d_imm", n),   bus16.pred_imm,            vecs[n].eimm);
      check($sformatf("vec%0d_cnt", n),   {16'b0, bus16.mispred_count}, vecs[n].ecnt);
    end

    // Narrow counter instance: 20 mispredicts must stop at 15.
    reset4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bus4.upd_valid = 1'b1;
      bus4.upd_pc    = $urandom;
      bus4.upd_taken = 1'b1;
      bus4.upd_pred  = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("cnt4_step%0d", k), {28'b0, bus4.mispred_count}, (k > 15) ? 32'd15 : k);
    end
    bus4.upd_valid = 1'b0;

    // Randomized traffic against the reference model.
    apply(mk(1,0,32'h0,32'h0, 0,32'h0,0,0, 0,0,32'h0,0));
    for (int c = 0; c < 400; c++) begin
      v.rst  = ($urandom_range(0, 99) == 0);
      v.lv   = $urandom_range(0, 1);
      v.lpc  = ($urandom & 32'hFFFF_FFC0) | $urandom_range(0, 7);
      v.limm = $urandom;
      v.uv   = $urandom_range(0, 1);
      v.upc  = ($urandom & 32'hFFFF_FFC0) | $urandom_range(0, 7);
      v.ut   = $urandom_range(0, 1);
      v.up   = $urandom_range(0, 1);
      apply(v);
      check("rnd_valid", {31'b0, bus16.pred_valid}, {31'b0, m_valid});
      check("rnd_taken", {31'b0, bus16.pred_taken}, {31'b0, m_taken});
      check("rnd_imm",   bus16.pred_imm,            m_imm);
      check("rnd_cnt",   {16'b0, bus16.mispred_count}, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
